// File: rtl/mult_sched_pkg.sv
// Shared definitions for the round-robin multiplier scheduler: size limits,
// default pipeline depth and the round-robin pick function.
package mult_sched_pkg;

  localparam int NREQ_MAX    = 8;
  localparam int LAT_DEFAULT = 2;
  localparam int IDX_W       = $clog2(NREQ_MAX);

  // Returns a one-hot grant: the first set bit of valid found when searching
  // upward from ptr+1 and wrapping at nreq. Returns all zeros if nothing is set.
  function automatic logic [NREQ_MAX-1:0] rr_pick(
    input logic [NREQ_MAX-1:0] valid,
    input logic [IDX_W-1:0]    ptr,
    input int unsigned         nreq
  );
    logic [NREQ_MAX-1:0] grant;
    logic                found;
    int unsigned         idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ_MAX; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= nreq) idx = idx - nreq;
      if (k <= nreq && !found && valid[idx[IDX_W-1:0]]) begin
        grant[idx[IDX_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/mult_pipe_2clk.sv
// LAT-stage registered unsigned multiplier. A valid bit and a one-hot tag
// travel beside the data so each product can be routed back to its issuer.
// The last stage is the response register seen by the requesters.
module mult_pipe_2clk
  import mult_sched_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAG_W = 2,
  parameter int LAT   = LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [W-1:0]     op1,
  input  logic [W-1:0]     op2,
  output logic             done_valid,
  output logic [TAG_W-1:0] done_tag,
  output logic [W-1:0]     product
);

  logic             valid_q [LAT];
  logic [TAG_W-1:0] tag_q   [LAT];

  // Valid/tag shift register; the tag is zeroed with the valid bit so the
  // final stage can drive the one-hot response strobe directly.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with <= so every stage samples the value from
    // before this edge; blocking assignments would collapse the shift chain.
    if (reset) begin
      for (int k = 0; k < LAT; k++) begin
        valid_q[k] <= 1'b0;
        tag_q[k]   <= '0;
      end
    end else begin
      valid_q[0] <= issue_valid;
      tag_q[0]   <= issue_valid ? issue_tag : '0;
      for (int k = 1; k < LAT; k++) begin
        valid_q[k] <= valid_q[k-1];
        tag_q[k]   <= tag_q[k-1];
      end
    end
  end

  assign done_valid = valid_q[LAT-1];
  assign done_tag   = tag_q[LAT-1];

  if (LAT == 1) begin : g_single
    logic [W-1:0] prod_q;

    // Single stage: the truncated product is registered at the issue edge.
    always_ff @(posedge clk or posedge reset) begin
      // NOTE: the data registers are reset as well because the product output
      // must read zero after reset; they load only with a valid bit, so the
      // last product is held between responses.
      if (reset)            prod_q <= '0;
      else if (issue_valid) prod_q <= op1 * op2;
    end

    assign product = prod_q;
  end else begin : g_multi
    logic [W-1:0] op1_q;
    logic [W-1:0] op2_q;
    logic [W-1:0] prod_q [1:LAT-1];

    // Stage 0 captures operands; stage 1 multiplies; later stages delay.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        op1_q <= '0;
        op2_q <= '0;
        for (int k = 1; k < LAT; k++) prod_q[k] <= '0;
      end else begin
        if (issue_valid) begin
          op1_q <= op1;
          op2_q <= op2;
        end
        if (valid_q[0]) prod_q[1] <= op1_q * op2_q;
        for (int k = 2; k < LAT; k++) begin
          if (valid_q[k-1]) prod_q[k] <= prod_q[k-1];
        end
      end
    end

    assign product = prod_q[LAT-1];
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ
// requesters. One operand pair is accepted per clock; its product returns to
// the issuing requester exactly LAT cycles later with a one-hot strobe.
module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int LAT  = LAT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*W-1:0]          req_op1,
  input  logic [NREQ*W-1:0]          req_op2,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [W-1:0]               rsp_data,
  output logic [$clog2(LAT+1)-1:0]   inflight
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(LAT + 1);

  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    winner;
  logic [NREQ_MAX-1:0] valid_ext;
  logic [NREQ_MAX-1:0] grant_ext;
  logic [W-1:0]        sel_op1;
  logic [W-1:0]        sel_op2;
  logic                transfer;
  logic                retire;

  // Arbitration: widen the request vector for the shared pick function.
  always_comb begin
    // NOTE: every signal gets a default before conditional code so no path
    // leaves it unassigned, which would infer a latch.
    valid_ext           = '0;
    valid_ext[NREQ-1:0] = req_valid;
    grant_ext           = rr_pick(valid_ext, IDX_W'(ptr_q), NREQ);
  end

  if (NREQ < NREQ_MAX) begin : g_pad
    logic grant_unused;
    assign grant_unused = |grant_ext[NREQ_MAX-1:NREQ];
  end

  assign req_ready = grant_ext[NREQ-1:0];
  assign transfer  = |req_ready;

  // Winner index and AND-OR operand mux driven by the one-hot grant.
  always_comb begin
    winner  = '0;
    sel_op1 = '0;
    sel_op2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) winner = PTR_W'(i);
      sel_op1 = sel_op1 | (req_op1[i*W +: W] & {W{req_ready[i]}});
      sel_op2 = sel_op2 | (req_op2[i*W +: W] & {W{req_ready[i]}});
    end
  end

  // Round-robin pointer moves to the winner only when a transfer happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         ptr_q <= PTR_W'(NREQ - 1);
    else if (transfer) ptr_q <= winner;
  end

  mult_pipe_2clk #(
    .W     (W),
    .TAG_W (NREQ),
    .LAT   (LAT)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (transfer),
    .issue_tag   (req_ready),
    .op1         (sel_op1),
    .op2         (sel_op2),
    .done_valid  (retire),
    .done_tag    (rsp_valid),
    .product     (rsp_data)
  );

  // Occupancy counter: +1 on issue, -1 when a response is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else if (transfer && !retire) begin
      inflight <= inflight + CNT_W'(1);
    end else if (!transfer && retire) begin
      inflight <= inflight - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler (NREQ=4): directed scenarios followed by 1000
// random cycles, checked by a scoreboard fed from observed handshakes.
module tb_mult_rr_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_op1;
  logic [NREQ*W-1:0] req_op2;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic [1:0]        inflight;

  always #5 clk = ~clk;

  mult_rr_scheduler #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .inflight  (inflight)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: first requesting index after the last winner, wrapping.
  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last + k) % NREQ;
      if (v[i]) return NREQ'(1) << i;
    end
    return '0;
  endfunction

  typedef struct {
    int           due;
    int           req;
    logic [W-1:0] prod;
  } exp_t;

  exp_t            sb[$];
  int              cyc = 0;
  int              mptr = NREQ - 1;
  logic [W-1:0]    last_data = '0;
  int              wait_cnt[NREQ];
  logic [NREQ-1:0] mon_grant;
  logic [NREQ-1:0] mon_rv;
  logic [NREQ-1:0] mon_hs;
  logic [W-1:0]    mon_a, mon_b, mon_p;

  // Monitor/scoreboard: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      mptr      = NREQ - 1;
      last_data = '0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    end else begin
      cyc++;
      check("inflight", 64'(inflight), 64'(sb.size()));
      mon_grant = model_grant(req_valid, mptr);
      check("req_ready", 64'(req_ready), 64'(mon_grant));
      mon_rv = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_rv    = NREQ'(1) << sb[0].req;
        last_data = sb[0].prod;
        void'(sb.pop_front());
      end
      check("rsp_valid", 64'(rsp_valid), 64'(mon_rv));
      check("rsp_data", 64'(rsp_data), 64'(last_data));
      mon_hs = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (mon_hs[i]) begin
          mon_a = req_op1[i*W +: W];
          mon_b = req_op2[i*W +: W];
          mon_p = mon_a * mon_b;
          sb.push_back('{due: cyc + LAT, req: i, prod: mon_p});
          mptr = i;
          check("wait_bound", 64'(wait_cnt[i] < NREQ), 64'd1);
          wait_cnt[i] = 0;
        end else if (req_valid[i]) begin
          wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op1[i*W +: W] = a;
    req_op2[i*W +: W] = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) next_cycle();
  endtask

  logic [NREQ-1:0] seen_grant;

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_op1   = '0;
    req_op2   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    next_cycle();

    // 1: single request is granted combinationally, 2*7 returns 14.
    set_op(0, 32'd2, 32'd7);
    req_valid = 4'b0001;
    #1 check("t1_ready_now", 64'(req_ready), 64'h1);
    next_cycle();
    idle(3);

    // 2: two requesters alternate.
    req_valid = 4'b0011;
    for (int n = 0; n < 6; n++) begin
      set_op(0, $urandom, $urandom);
      set_op(1, $urandom, $urandom);
      next_cycle();
    end
    idle(3);

    // 3: requester 1 alone, back to back.
    req_valid = 4'b0010;
    for (int k = 5; k <= 7; k++) begin
      set_op(1, 32'd3, 32'(k));
      next_cycle();
    end
    idle(3);

    // 4: truncation of the upper product bits.
    set_op(2, 32'hFFFF_FFFF, 32'd2);
    req_valid = 4'b0100;
    next_cycle();
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    check("t4_trunc_data", 64'(rsp_data), 64'hFFFF_FFFE);
    check("t4_trunc_tag", 64'(rsp_valid), 64'h4);
    next_cycle();
    idle(2);

    // 5: reset with two products in flight.
    req_valid = 4'b0011;
    next_cycle();
    next_cycle();
    #2 reset = 1'b1;
    #1;
    check("t5_rsp_valid_clr", 64'(rsp_valid), 64'h0);
    check("t5_inflight_clr", 64'(inflight), 64'h0);
    check("t5_rsp_data_clr", 64'(rsp_data), 64'h0);
    next_cycle();
    reset = 1'b0;
    #1 check("t5_first_grant", 64'(req_ready), 64'h1);
    repeat (4) next_cycle();
    idle(3);

    // 6: random traffic; pending requesters usually hold, sometimes drop.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      seen_grant = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        set_op(i, $urandom, $urandom);
        if (!req_valid[i] || seen_grant[i])
          req_valid[i] = ($urandom_range(0, 2) != 0);
        else if ($urandom_range(0, 15) == 0)
          req_valid[i] = 1'b0;
      end
    end
    idle(LAT + 2);
    @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
